// File: rtl/fft_pkg.sv
// -----------------------------------------------------------------------------
// fft_pkg
// Shared definitions for the FFT twiddle path.
//   tw_state_t  : sequencer FSM states (IDLE, RUN, DONE)
//   TW_N, TW_W  : default FFT length and twiddle word width
//   LOG2N       : number of radix-2 stages for TW_N
//   STAGE_W/K_W : widths of the stage index and of the exponent k
//   tw_qtable() : elaboration-time builder for one quarter-wave cosine entry,
//                 T[m] = round(cos(2*pi*m/N) * (2^(W-1)-1)), m = 0..N/4
// -----------------------------------------------------------------------------
package fft_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } tw_state_t;

  localparam int TW_N    = 16;
  localparam int TW_W    = 16;
  localparam int LOG2N   = $clog2(TW_N);
  localparam int STAGE_W = $clog2(LOG2N);
  localparam int K_W     = $clog2(TW_N / 2);

  // Only called with constant arguments, so the real math folds away at
  // elaboration. Entries are non-negative (first quadrant), so +0.5 then
  // truncation is round-to-nearest.
  function automatic int tw_qtable(input int m, input int n, input int w);
    real amp;
    real v;
    amp = real'((1 << (w - 1)) - 1);
    v   = $cos(2.0 * 3.14159265358979323846 * real'(m) / real'(n)) * amp;
    return $rtoi(v + 0.5);
  endfunction

endpackage

// File: rtl/twiddle_qrom.sv
// -----------------------------------------------------------------------------
// twiddle_qrom
// Registered quarter-wave twiddle lookup. Folds exponent k (0..N/2-1) onto the
// quarter-wave cosine table and returns the sign-corrected cos/sin pair one
// clock after k is presented with en high.
// Ports:
//   clk, rst       : clock, asynchronous active-high reset
//   en             : pipeline enable; output register loads only when high
//   k   [KW-1:0]   : twiddle exponent
//   cos_q [W-1:0]  : signed cos(2*pi*k/N), registered
//   sin_q [W-1:0]  : signed sin(2*pi*k/N), registered
// -----------------------------------------------------------------------------
module twiddle_qrom
  import fft_pkg::*;
#(
  parameter int W  = TW_W,
  parameter int N  = TW_N,
  parameter int KW = $clog2(N / 2)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [KW-1:0]       k,
  output logic signed [W-1:0] cos_q,
  output logic signed [W-1:0] sin_q
);

  localparam int Q = N / 4;
  localparam logic [KW:0] HALF = (KW + 1)'(N / 2);
  localparam logic [KW:0] QTR  = (KW + 1)'(N / 4);

  // Q+1 entries need exactly KW index bits because Q = 2^(KW-1).
  logic signed [W-1:0] qtab [0:Q];

  for (genvar m = 0; m <= Q; m++) begin : g_tab
    localparam int TV = tw_qtable(m, N, W);
    assign qtab[m] = TV[W-1:0];
  end

  logic [KW:0]         kx;
  logic [KW-1:0]       cidx;
  logic [KW-1:0]       sidx;
  logic                cneg;
  logic signed [W-1:0] cos_d;
  logic signed [W-1:0] sin_d;

  // Second quadrant (k > N/4): cos is the mirrored entry negated, sin is
  // read straight from the table. Table magnitudes never reach 2^(W-1), so
  // the negation cannot overflow.
  always_comb begin
    kx = {1'b0, k};
    if (kx <= QTR) begin
      cidx = KW'(kx);
      sidx = KW'(QTR - kx);
      cneg = 1'b0;
    end else begin
      cidx = KW'(HALF - kx);
      sidx = KW'(kx - QTR);
      cneg = 1'b1;
    end
    cos_d = cneg ? -qtab[cidx] : qtab[cidx];
    sin_d = qtab[sidx];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cos_q <= '0;
      sin_q <= '0;
    end else if (en) begin
      cos_q <= cos_d;
      sin_q <= sin_d;
    end
  end

endmodule

// File: rtl/twiddle_sequencer.sv
// -----------------------------------------------------------------------------
// twiddle_sequencer
// Emits the ordered twiddle stream for a radix-2 FFT: stage s = 0..log2N-1
// (outer), butterfly b = 0..N/2-1 (inner), one cos/sin pair per butterfly.
// Two pipeline stages: exponent/table-read register (twiddle_qrom plus the
// stage/k/valid tags), then the output register.
// Build option: define TWIDDLE_DIF_EN for decimation-in-frequency ordering
// k = (b mod N/2^(s+1)) * 2^s; default is DIT, k = (b mod 2^s) * N/2^(s+1).
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   start           : one-cycle request, honoured only in IDLE
//   busy            : high while the sequence runs (FSM in RUN)
//   done            : one-cycle pulse after the final handshake
//   tw_valid/ready  : output handshake
//   tw_cos, tw_sin  : signed Q1.(W-1) twiddle pair (sin without the minus)
//   tw_stage, tw_k  : stage and exponent of the presented pair
//   dbg_state       : current FSM state, for observation only
// Handshake: a pair transfers on a cycle where tw_valid && tw_ready. Once
// tw_valid is high it stays high, with tw_cos/tw_sin/tw_stage/tw_k stable,
// until that transfer happens. The whole pipeline and the counters advance
// only when the output register is empty or being drained.
// -----------------------------------------------------------------------------
module twiddle_sequencer
  import fft_pkg::*;
#(
  parameter int W = TW_W,
  parameter int N = TW_N
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic                          tw_valid,
  input  logic                          tw_ready,
  output logic signed [W-1:0]           tw_cos,
  output logic signed [W-1:0]           tw_sin,
  output logic [$clog2($clog2(N))-1:0]  tw_stage,
  output logic [$clog2(N/2)-1:0]        tw_k,
  output tw_state_t                     dbg_state
);

  localparam int L  = $clog2(N);
  localparam int SW = $clog2(L);
  localparam int KW = $clog2(N / 2);

  tw_state_t           state;
  tw_state_t           state_nxt;
  logic [SW-1:0]       s_cnt;
  logic [KW-1:0]       b_cnt;
  logic [KW-1:0]       k_cur;
  logic                all_issued;
  logic                en;
  logic                issue;
  logic                last_pair;
  logic                last_hs;
  logic                v1;
  logic [SW-1:0]       s1;
  logic [KW-1:0]       k1;
  logic signed [W-1:0] cos1;
  logic signed [W-1:0] sin1;

  assign en        = !tw_valid || tw_ready;
  assign last_pair = (s_cnt == SW'(L - 1)) && (b_cnt == KW'(N / 2 - 1));
  assign dbg_state = state;

  // Exponent from the counters. Shifting within a KW-bit result drops the
  // high bits of b, which is exactly the "mod" in both orderings
  // (shift distance KW-s for DIT, s for DIF).
  always_comb begin
`ifdef TWIDDLE_DIF_EN
    k_cur = b_cnt << s_cnt;
`else
    k_cur = b_cnt << (KW - int'(s_cnt));
`endif
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)   state_nxt = RUN;
      RUN:     if (last_hs) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // The first pair is issued in the same cycle start is accepted, so it
  // reaches the output two cycles later. The final handshake is the one that
  // drains the output register once everything is issued and stage 1 is empty.
  always_comb begin
    busy    = (state == RUN);
    done    = (state == DONE);
    issue   = en && (((state == IDLE) && start) || ((state == RUN) && !all_issued));
    last_hs = (state == RUN) && all_issued && !v1 && tw_valid && tw_ready;
  end

  // ---------------- stage/butterfly counters ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_cnt      <= '0;
      b_cnt      <= '0;
      all_issued <= 1'b0;
    end else begin
      if (issue) begin
        if (last_pair) begin
          s_cnt <= '0;
          b_cnt <= '0;
        end else if (b_cnt == KW'(N / 2 - 1)) begin
          b_cnt <= '0;
          s_cnt <= s_cnt + SW'(1);
        end else begin
          b_cnt <= b_cnt + KW'(1);
        end
      end
      if (state == DONE)          all_issued <= 1'b0;
      else if (issue && last_pair) all_issued <= 1'b1;
    end
  end

  // ---------------- pipeline stage 1: table read + tags ----------------
  twiddle_qrom #(
    .W  (W),
    .N  (N),
    .KW (KW)
  ) u_qrom (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .k     (k_cur),
    .cos_q (cos1),
    .sin_q (sin1)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1 <= 1'b0;
      s1 <= '0;
      k1 <= '0;
    end else if (en) begin
      v1 <= issue;
      s1 <= s_cnt;
      k1 <= k_cur;
    end
  end

  // ---------------- pipeline stage 2: output register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tw_valid <= 1'b0;
      tw_stage <= '0;
      tw_k     <= '0;
      tw_cos   <= '0;
      tw_sin   <= '0;
    end else if (en) begin
      tw_valid <= v1;
      tw_stage <= s1;
      tw_k     <= k1;
      tw_cos   <= cos1;
      tw_sin   <= sin1;
    end
  end

endmodule
